// File: rtl/ysyx_23060187_imem.sv
// Instruction-memory responder: valid/ready fetch request in, registered instruction out after LATENCY cycles.
// Define YSYX_23060187_IMEM_RAND_DELAY_EN to add an LFSR-driven 0..7 cycle random extra wait per request.
module ysyx_23060187_imem #(
  parameter logic [31:0] BASE      = 32'h8000_0000,
  parameter int          DEPTH     = 4096,
  parameter int          LATENCY   = 1,
  parameter string       INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [31:0] req_pc,
  output logic        req_ready,
  output logic        mem_valid,
  output logic [31:0] inst_out,
  input  logic        resp_ready,
  input  logic        wr_en,
  input  logic [31:0] wr_addr,
  input  logic [31:0] wr_data
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = $clog2(LATENCY + 8);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  logic [31:0]      mem [DEPTH];
  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next, wait_total;
  logic [31:0]      pc_q, pc_next;
  logic [2:0]       extra;

  logic [31:0]      rd_off, wr_off;
  logic             rd_hit, wr_hit;
  logic [AW-1:0]    rd_idx, wr_idx;

`ifdef YSYX_23060187_IMEM_RAND_DELAY_EN
  logic [15:0] lfsr;

  // Fibonacci LFSR, taps 16,14,13,11; only its low bits feed the wait time.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr <= 16'hACE1;
    else     lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  assign extra = lfsr[2:0];
`else
  assign extra = 3'd0;
`endif

  // Cycles spent between acceptance and entering RESP; zero means straight to RESP.
  assign wait_total = CNT_W'(LATENCY - 1) + CNT_W'(extra);

  // The pc being used for the read is the one latched at this edge, so decode pc_next.
  assign rd_off = pc_next - BASE;
  assign rd_hit = (pc_next >= BASE) && ((rd_off >> 2) < 32'(DEPTH));
  assign rd_idx = rd_off[AW+1:2];

  assign wr_off = wr_addr - BASE;
  assign wr_hit = (wr_addr >= BASE) && ((wr_off >> 2) < 32'(DEPTH));
  assign wr_idx = wr_off[AW+1:2];

  // NOTE: every variable gets a default before the case so no path can infer a latch.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    pc_next    = pc_q;
    unique case (state)
      IDLE: begin
        if (req_valid && req_ready) begin
          pc_next = req_pc;
          if (wait_total == '0) begin
            state_next = RESP;
          end else begin
            cnt_next   = wait_total - CNT_W'(1);
            state_next = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt == '0) state_next = RESP;
        else           cnt_next   = cnt - CNT_W'(1);
      end
      RESP: begin
        if (mem_valid && resp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      pc_q      <= '0;
      req_ready <= 1'b0;
      mem_valid <= 1'b0;
      inst_out  <= '0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      pc_q      <= pc_next;
      req_ready <= (state_next == IDLE);
      mem_valid <= (state_next == RESP);
      if (state_next == RESP && state != RESP)
        inst_out <= rd_hit ? mem[rd_idx] : 32'h0000_0000;
    end
  end

  // NOTE: the array has no reset so the loaded program survives rst and maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en && wr_hit) mem[wr_idx] <= wr_data;
  end

endmodule
